// File: rtl/pipe_stage.sv
// Two-entry skid-buffered pipeline stage splitting the payload into hi/lo fields.
// Optional stall counter enabled by defining PIPE_STAGE_STATS_EN.
//
// state    | meaning
// ---------+-------------------------------
// ST_EMPTY | no entries held
// ST_ONE   | main valid, skid empty
// ST_TWO   | main and skid valid, input stalled
module pipe_stage #(
  parameter int WIDTH    = 8,
  parameter int HI_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [HI_WIDTH-1:0]       out_hi,
  output logic [WIDTH-HI_WIDTH-1:0] out_lo
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]               stall_count
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            state_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_d   = ST_TWO;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            load_main_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so neither depends
  // combinationally on in_valid or out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d != ST_EMPTY);
      in_ready  <= (state_d != ST_TWO);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign out_hi = main_q[WIDTH-1 -: HI_WIDTH];
  assign out_lo = main_q[WIDTH-HI_WIDTH-1:0];

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_q;

  // Saturating; deliberately ignores flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage;
  localparam int WIDTH    = 8;
  localparam int HI_WIDTH = 4;
  localparam int LO_WIDTH = WIDTH - HI_WIDTH;

  logic                clk;
  logic                reset;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic                out_valid;
  logic                out_ready;
  logic [HI_WIDTH-1:0] out_hi;
  logic [LO_WIDTH-1:0] out_lo;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]         stall_count;
`endif

  pipe_stage #(.WIDTH(WIDTH), .HI_WIDTH(HI_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_lo    (out_lo)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       flush;
    logic       in_valid;
    logic [7:0] data;
    logic       out_ready;
    logic       exp_ov;
    logic       exp_ir;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[15];
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] head;
  logic m_in_xfer;
  logic m_out_xfer;

  initial begin
    //           flush  in_v   data   o_rdy  ov     ir     head
    vecs[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h12};
    vecs[4]  = '{1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 8'h12};
    vecs[5]  = '{1'b0, 1'b1, 8'h56, 1'b0, 1'b1, 1'b0, 8'h12};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h34};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 8'h77};
    vecs[9]  = '{1'b0, 1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 8'h77};
    vecs[10] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 8'h99};
    vecs[13] = '{1'b0, 1'b1, 8'hAB, 1'b1, 1'b1, 1'b1, 8'hAB};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_data", 64'({out_hi, out_lo}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'(1));
    chk("rel_out_valid", 64'(out_valid), 64'(0));

    // Vector table; payload compared only while out_valid is expected.
    for (int i = 0; i < 15; i++) begin
      flush = vecs[i].flush; in_valid = vecs[i].in_valid;
      in_data = vecs[i].data; out_ready = vecs[i].out_ready;
      @(negedge clk);
      chk($sformatf("vec%0d_ov", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_ir", i), 64'(in_ready), 64'(vecs[i].exp_ir));
      if (vecs[i].exp_ov) begin
        chk($sformatf("vec%0d_hi", i), 64'(out_hi), 64'(vecs[i].exp_data[7:4]));
        chk($sformatf("vec%0d_lo", i), 64'(out_lo), 64'(vecs[i].exp_data[3:0]));
      end
    end
    flush = 1'b0;

    // Back-to-back stream: one output per cycle, in_ready never drops.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i); out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("stream%0d_ov", i), 64'(out_valid), 64'(1));
      chk($sformatf("stream%0d_ir", i), 64'(in_ready), 64'(1));
      chk($sformatf("stream%0d_data", i), 64'({out_hi, out_lo}), 64'(i));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drain_ov", 64'(out_valid), 64'(0));

    // Fill to TWO, then assert reset between edges.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
    @(negedge clk);
    in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    chk("two_ir", 64'(in_ready), 64'(0));
    #2 reset = 1'b0;
    #1;
    chk("midrst_ov", 64'(out_valid), 64'(0));
    chk("midrst_ir", 64'(in_ready), 64'(0));
    chk("midrst_data", 64'({out_hi, out_lo}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ir", 64'(in_ready), 64'(1));
    chk("midrst_rel_ov", 64'(out_valid), 64'(0));

    // Randomized traffic against a FIFO-of-two model.
    model_q.delete();
    for (int n = 0; n < 3000; n++) begin
      chk("rnd_ov", 64'(out_valid), 64'(model_q.size() > 0));
      chk("rnd_ir", 64'(in_ready), 64'(model_q.size() < 2));
      if (model_q.size() > 0) begin
        head = model_q[0];
        chk("rnd_data", 64'({out_hi, out_lo}), 64'(head));
      end
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'($urandom);
      m_in_xfer  = in_valid && (model_q.size() < 2);
      m_out_xfer = out_ready && (model_q.size() > 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_out_xfer) void'(model_q.pop_front());
        if (m_in_xfer) model_q.push_back(in_data);
      end
      @(negedge clk);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);

`ifdef PIPE_STAGE_STATS_EN
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("stall_rst", 64'(stall_count), 64'(0));
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_five", 64'(stall_count), 64'(5));
    repeat (65540) @(negedge clk);
    chk("stall_sat", 64'(stall_count), 64'(16'hFFFF));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("stall_flush", 64'(stall_count), 64'(16'hFFFF));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
